norm_arb: RTL and testbench
===========================

NORM_ARB -- requirements
Module: norm_arb

Interface
REQ-001 SHALL have parameter EXP_W, default 11, exponent width.
REQ-002 SHALL have parameter TAG_W, default 4, requester tag width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in0_valid / in1_valid  input  1  requester operand valid.
REQ-006 SHALL have ports in0_ready / in1_ready  output  1  requester operand accepted this cycle when valid is also high.
REQ-007 SHALL have ports in0_mant / in1_mant  input  64  unnormalized mantissa.
REQ-008 SHALL have ports in0_exp / in1_exp  input  EXP_W  unbiased-positive exponent.
REQ-009 SHALL have ports in0_tag / in1_tag  input  TAG_W  opaque tag, returned unchanged.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port out_mant  output  64  normalized mantissa.
REQ-013 SHALL have port out_exp  output  EXP_W  adjusted exponent.
REQ-014 SHALL have port out_tag  output  TAG_W  tag of the source operand.
REQ-015 SHALL have port out_src  output  1  requester index, 0 or 1.
REQ-016 SHALL have ports out_zero / out_uf  output  1  zero-mantissa flag / exponent-underflow flag.

Function
REQ-017 SHALL share one instance of the team's existing 64-bit leading-zero counter (7-bit count, 64 for an all-zero input) between both requesters.
REQ-018 SHALL form a 2-stage pipeline: stage A registers the granted operand; stage B registers the count, shift and exponent result onto the out_* outputs.
REQ-019 SHALL accept an operand on a cycle where inN_valid and inN_ready are both high, and SHALL present out_valid exactly 2 cycles later when out_ready stays high.
REQ-020 SHALL advance stage B when it is empty or out_ready is high, and SHALL advance stage A only when stage B advances or stage A is empty.
REQ-021 SHALL assert inN_ready only for the granted requester, and only when stage A can load; the other requester's ready SHALL be low.
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0; there is no combinational path from out_ready to out_*.
REQ-023 SHALL round-robin grant: with one requester valid it wins; with both valid, the requester not granted last wins; the pointer updates only on an accepted transfer.
REQ-024 SHALL produce, for count c < exp: out_mant = mant << c, out_exp = exp - c, out_uf=0.
REQ-025 SHALL produce, for count c >= exp with a nonzero mantissa: out_mant = mant << exp, out_exp = 0, out_uf=1.
REQ-026 SHALL produce, for a zero mantissa: out_mant=0, out_exp=0, out_zero=1, out_uf=0.
REQ-027 SHALL sustain 1 result per cycle under continuous valid and out_ready, with no bubbles.

Reset
REQ-028 SHALL clear both stage valid bits on rst, so that out_valid=0 and in0_ready/in1_ready=0 during the reset cycle.
REQ-029 SHALL reset out_mant, out_exp, out_tag, out_src, out_zero and out_uf to 0, and the round-robin pointer so that requester 0 wins the first tie.
REQ-030 SHALL discard in-flight operands when rst is asserted mid-operation; no result for them is ever emitted.

Configuration
REQ-031 SHALL, with macro NORM_ARB_RR_EN defined, use the round-robin grant of REQ-023.
REQ-032 SHALL, without NORM_ARB_RR_EN, use fixed priority: requester 0 always wins a tie and the pointer register is absent; all other behaviour is identical.

Verification
REQ-033 Single request: in0 mant=0x0000_0000_0000_00F0, exp=100, tag=3 -> 2 cycles later out_mant=0xF000_0000_0000_0000, out_exp=44, out_tag=3, out_src=0, out_zero=0, out_uf=0.
REQ-034 Underflow: in1 mant=0x0000_0000_0000_0001, exp=10 -> out_mant=0x0000_0000_0000_0400, out_exp=0, out_uf=1, out_src=1.
REQ-035 Zero: in0 mant=0, exp=500 -> out_mant=0, out_exp=0, out_zero=1.
REQ-036 Contention: both valid continuously for 6 transfers after reset -> out_src sequence 0,1,0,1,0,1 with RR_EN; 0,0,0,0,0,0 without it.
REQ-037 Backpressure: hold out_ready=0 for 5 cycles with both stages full -> out_* stable, both inN_ready=0; release -> results drain in order with no loss or duplication.
REQ-038 Reset mid-flight: assert rst with both stages full -> next cycle out_valid=0, pointer back to its reset value, and no stale result afterwards.

Source files
------------

// File: rtl/norm_arb.sv
// Two-requester normalizer: arbitrates into a shared 64-bit leading-zero count and shift.
// Macro NORM_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority. EXP_W must be >= 7.

module norm_arb_lzc64 (
  input  logic [63:0] din,
  output logic [6:0]  cnt
);
  // The highest set bit is visited last, so it sets the final count; all-zero input gives 64.
  always_comb begin
    cnt = 7'd64;
    for (int i = 0; i < 64; i++) begin
      if (din[i]) cnt = 7'(63 - i);
    end
  end
endmodule

module norm_arb #(
  parameter int EXP_W = 11,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [63:0]      in0_mant,
  input  logic [EXP_W-1:0] in0_exp,
  input  logic [TAG_W-1:0] in0_tag,
  input  logic             in1_valid,
  output logic             in1_ready,
  input  logic [63:0]      in1_mant,
  input  logic [EXP_W-1:0] in1_exp,
  input  logic [TAG_W-1:0] in1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_mant,
  output logic [EXP_W-1:0] out_exp,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic             out_zero,
  output logic             out_uf
);

  logic             a_valid_q, a_valid_d;
  logic [63:0]      a_mant_q, a_mant_d;
  logic [EXP_W-1:0] a_exp_q, a_exp_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;
  logic             a_src_q, a_src_d;

  logic             b_valid_q, b_valid_d;
  logic [63:0]      b_mant_q, b_mant_d;
  logic [EXP_W-1:0] b_exp_q, b_exp_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;
  logic             b_src_q, b_src_d;
  logic             b_zero_q, b_zero_d;
  logic             b_uf_q, b_uf_d;

  logic       adv_b, adv_a, gnt1, fire;
  logic [6:0] lz_cnt;
  logic       c_lt_e;

  assign adv_b = ~b_valid_q | out_ready;
  assign adv_a = adv_b | ~a_valid_q;

`ifdef NORM_ARB_RR_EN
  logic last_q, last_d;
  // last_q holds the most recently granted requester; the other one wins a tie.
  assign gnt1   = in1_valid & (~in0_valid | ~last_q);
  assign last_d = fire ? gnt1 : last_q;
`else
  assign gnt1 = in1_valid & ~in0_valid;
`endif

  assign in0_ready = adv_a & ~rst & ~gnt1;
  assign in1_ready = adv_a & ~rst & gnt1;
  assign fire      = (in0_valid & in0_ready) | (in1_valid & in1_ready);

  always_comb begin
    a_valid_d = a_valid_q;
    a_mant_d  = a_mant_q;
    a_exp_d   = a_exp_q;
    a_tag_d   = a_tag_q;
    a_src_d   = a_src_q;
    if (adv_a) a_valid_d = fire;
    if (fire) begin
      a_mant_d = gnt1 ? in1_mant : in0_mant;
      a_exp_d  = gnt1 ? in1_exp  : in0_exp;
      a_tag_d  = gnt1 ? in1_tag  : in0_tag;
      a_src_d  = gnt1;
    end
  end

  norm_arb_lzc64 u_lzc (
    .din (a_mant_q),
    .cnt (lz_cnt)
  );

  assign c_lt_e = EXP_W'(lz_cnt) < a_exp_q;

  always_comb begin
    b_valid_d = b_valid_q;
    b_mant_d  = b_mant_q;
    b_exp_d   = b_exp_q;
    b_tag_d   = b_tag_q;
    b_src_d   = b_src_q;
    b_zero_d  = b_zero_q;
    b_uf_d    = b_uf_q;
    if (adv_b) b_valid_d = a_valid_q;
    if (adv_b && a_valid_q) begin
      b_tag_d = a_tag_q;
      b_src_d = a_src_q;
      if (lz_cnt[6]) begin
        b_mant_d = '0;
        b_exp_d  = '0;
        b_zero_d = 1'b1;
        b_uf_d   = 1'b0;
      end else if (c_lt_e) begin
        b_mant_d = a_mant_q << lz_cnt[5:0];
        b_exp_d  = a_exp_q - EXP_W'(lz_cnt);
        b_zero_d = 1'b0;
        b_uf_d   = 1'b0;
      end else begin
        // Exponent runs out first: shift only as far as it allows (exp <= 63 here).
        b_mant_d = a_mant_q << a_exp_q[5:0];
        b_exp_d  = '0;
        b_zero_d = 1'b0;
        b_uf_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_mant_q  <= '0;
      a_exp_q   <= '0;
      a_tag_q   <= '0;
      a_src_q   <= 1'b0;
      b_valid_q <= 1'b0;
      b_mant_q  <= '0;
      b_exp_q   <= '0;
      b_tag_q   <= '0;
      b_src_q   <= 1'b0;
      b_zero_q  <= 1'b0;
      b_uf_q    <= 1'b0;
`ifdef NORM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      a_valid_q <= a_valid_d;
      a_mant_q  <= a_mant_d;
      a_exp_q   <= a_exp_d;
      a_tag_q   <= a_tag_d;
      a_src_q   <= a_src_d;
      b_valid_q <= b_valid_d;
      b_mant_q  <= b_mant_d;
      b_exp_q   <= b_exp_d;
      b_tag_q   <= b_tag_d;
      b_src_q   <= b_src_d;
      b_zero_q  <= b_zero_d;
      b_uf_q    <= b_uf_d;
`ifdef NORM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign out_valid = b_valid_q & ~rst;
  assign out_mant  = b_mant_q;
  assign out_exp   = b_exp_q;
  assign out_tag   = b_tag_q;
  assign out_src   = b_src_q;
  assign out_zero  = b_zero_q;
  assign out_uf    = b_uf_q;

endmodule

// File: tb/tb_norm_arb.sv
// Directed + random bench for norm_arb with a scoreboard of expected results.
// Contention expectations follow NORM_ARB_RR_EN when it is defined for the build.

module tb_norm_arb;
  localparam int EXP_W = 11;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [63:0]      mant;
    logic [EXP_W-1:0] exp;
    logic [TAG_W-1:0] tag;
    logic             src;
    logic             zero;
    logic             uf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in0_valid, in1_valid, in0_ready, in1_ready;
  logic [63:0]      in0_mant, in1_mant;
  logic [EXP_W-1:0] in0_exp, in1_exp;
  logic [TAG_W-1:0] in0_tag, in1_tag;
  logic             out_valid, out_ready;
  logic [63:0]      out_mant;
  logic [EXP_W-1:0] out_exp;
  logic [TAG_W-1:0] out_tag;
  logic             out_src, out_zero, out_uf;

  int   total = 0;
  int   bad   = 0;
  res_t sb[$];

  norm_arb #(.EXP_W(EXP_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_mant(in0_mant), .in0_exp(in0_exp), .in0_tag(in0_tag),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_mant(in1_mant), .in1_exp(in1_exp), .in1_tag(in1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant), .out_exp(out_exp),
    .out_tag(out_tag), .out_src(out_src), .out_zero(out_zero), .out_uf(out_uf)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [63:0] m, logic [EXP_W-1:0] e, logic [TAG_W-1:0] t, logic s);
    res_t r;
    logic [63:0] x;
    int c;
    r.tag = t; r.src = s; r.zero = 1'b0; r.uf = 1'b0;
    if (m == 64'd0) begin
      r.mant = '0; r.exp = '0; r.zero = 1'b1;
    end else begin
      c = 0; x = m;
      while (x[63] == 1'b0) begin x = x << 1; c++; end
      if (c < int'(e)) begin
        r.mant = m << c; r.exp = e - EXP_W'(c);
      end else begin
        r.mant = m << e; r.exp = '0; r.uf = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic res_t observed();
    return {out_mant, out_exp, out_tag, out_src, out_zero, out_uf};
  endfunction

  function automatic logic [63:0] rand_mant();
    logic [63:0] m;
    m = {$urandom, $urandom};
    return m >> $urandom_range(0, 64);
  endfunction

  function automatic logic [EXP_W-1:0] rand_exp();
    if ($urandom_range(0, 3) == 0) return EXP_W'($urandom_range(0, 2047));
    return EXP_W'($urandom_range(0, 70));
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic new_op0();
    in0_mant = rand_mant(); in0_exp = rand_exp(); in0_tag = TAG_W'($urandom);
  endtask

  task automatic new_op1();
    in1_mant = rand_mant(); in1_exp = rand_exp(); in1_tag = TAG_W'($urandom);
  endtask

  // One clock: sample handshakes at negedge, score them, return #1 after the rising edge.
  task automatic tick(output bit f0, output bit f1);
    res_t e, o;
    @(negedge clk);
    f0 = in0_valid && in0_ready;
    f1 = in1_valid && in1_ready;
    if (out_valid && out_ready) begin
      o = observed();
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_out got=%0h exp=none", o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("txn src=%0d tag=%0d mant=%h exp=%0d zero=%0b uf=%0b", o.src, o.tag, o.mant, o.exp, o.zero, o.uf);
        chk("result", 128'(o), 128'(e));
      end
    end
    if (f0) sb.push_back(model(in0_mant, in0_exp, in0_tag, 1'b0));
    if (f1) sb.push_back(model(in1_mant, in1_exp, in1_tag, 1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bit f0, f1;
    int n;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 20) begin tick(f0, f1); n++; end
    chk("drain_empty", 128'(sb.size()), 128'd0);
    tick(f0, f1);
    tick(f0, f1);
  endtask

  initial begin
    bit   f0, f1;
    int   nfire;
    res_t snap;
    rst = 1'b1; out_ready = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_mant = '0; in0_exp = '0; in0_tag = '0;
    in1_mant = '0; in1_exp = '0; in1_tag = '0;

    // Reset state
    @(posedge clk); #1;
    in0_valid = 1'b1; in1_valid = 1'b1;
    @(posedge clk); #1;
    chk("rst_out", 128'({out_valid, observed()}), 128'd0);
    chk("rst_ready", 128'({in0_ready, in1_ready}), 128'd0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    rst = 1'b0;

    // Single request on in0, with latency check
    in0_valid = 1'b1; in0_mant = 64'h0000_0000_0000_00F0; in0_exp = 11'd100; in0_tag = 4'd3;
    tick(f0, f1);
    chk("req033_accept", 128'(f0), 128'd1);
    in0_valid = 1'b0;
    chk("req033_lat1", 128'(out_valid), 128'd0);
    tick(f0, f1);
    chk("req033_lat2", 128'(out_valid), 128'd1);
    chk("req033", 128'(observed()), 128'({64'hF000_0000_0000_0000, 11'd44, 4'd3, 1'b0, 1'b0, 1'b0}));
    drain();

    // Underflow on in1
    in1_valid = 1'b1; in1_mant = 64'h1; in1_exp = 11'd10; in1_tag = 4'd5;
    tick(f0, f1);
    in1_valid = 1'b0;
    tick(f0, f1);
    chk("req034", 128'({out_valid, observed()}), 128'({1'b1, 64'h400, 11'd0, 4'd5, 1'b1, 1'b0, 1'b1}));
    drain();

    // Zero mantissa
    in0_valid = 1'b1; in0_mant = 64'h0; in0_exp = 11'd500; in0_tag = 4'd7;
    tick(f0, f1);
    in0_valid = 1'b0;
    tick(f0, f1);
    chk("req035", 128'({out_valid, observed()}), 128'({1'b1, 64'h0, 11'd0, 4'd7, 1'b0, 1'b1, 1'b0}));
    drain();

    // Boundaries: count == exp underflows, count == exp-1 just normalizes
    in0_valid = 1'b1; in0_mant = 64'h1; in0_exp = 11'd63; in0_tag = 4'd1;
    tick(f0, f1);
    in0_mant = 64'h1; in0_exp = 11'd64; in0_tag = 4'd2;
    tick(f0, f1);
    in0_valid = 1'b0;
    chk("edge_c_eq_e", 128'(observed()), 128'({64'h8000_0000_0000_0000, 11'd0, 4'd1, 1'b0, 1'b0, 1'b1}));
    tick(f0, f1);
    chk("edge_c_lt_e", 128'(observed()), 128'({64'h8000_0000_0000_0000, 11'd1, 4'd2, 1'b0, 1'b0, 1'b0}));
    drain();

    // Contention right after reset, full throughput
    rst = 1'b1;
    tick(f0, f1);
    rst = 1'b0;
    new_op0(); new_op1();
    in0_valid = 1'b1; in1_valid = 1'b1;
    nfire = 0;
    for (int i = 0; i < 6; i++) begin
      tick(f0, f1);
`ifdef NORM_ARB_RR_EN
      chk("contend_src", 128'(f1), 128'(i % 2));
`else
      chk("contend_src", 128'(f1), 128'd0);
`endif
      if (f0 || f1) nfire++;
      if (f0) new_op0();
      if (f1) new_op1();
    end
    chk("no_bubbles", 128'(nfire), 128'd6);
    drain();

    // Backpressure with both stages full
    out_ready = 1'b0;
    new_op0(); new_op1();
    in0_valid = 1'b1; in1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(f0, f1);
      if (f0) new_op0();
      if (f1) new_op1();
    end
    snap = observed();
    chk("bp_full_valid", 128'(out_valid), 128'd1);
    for (int i = 0; i < 5; i++) begin
      tick(f0, f1);
      chk("bp_ready", 128'({in0_ready, in1_ready}), 128'd0);
      chk("bp_stable", 128'({out_valid, observed()}), 128'({1'b1, snap}));
    end
    chk("bp_count", 128'(sb.size()), 128'd2);
    drain();

    // Reset mid-flight after in0-only traffic
    out_ready = 1'b0;
    new_op0();
    in0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(f0, f1);
      if (f0) new_op0();
    end
    chk("mid_full", 128'(out_valid), 128'd1);
    rst = 1'b1; in0_valid = 1'b0;
    tick(f0, f1);
    chk("mid_rst_out", 128'({out_valid, in0_ready, in1_ready}), 128'd0);
    sb.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_after_valid", 128'(out_valid), 128'd0);
    new_op0(); new_op1();
    in0_valid = 1'b1; in1_valid = 1'b1;
    tick(f0, f1);
    chk("mid_ptr_reset", 128'({f0, f1}), 128'b10);
    drain();

    // Random traffic with random backpressure
    for (int i = 0; i < 80; i++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      new_op0(); new_op1();
      tick(f0, f1);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
